alu_mc: RTL and testbench

Parametrised multi-cycle integer ALU for the single-issue datapath.
- Single-cycle ops (add/sub/logic/shift/compare, lui/auipc) return a registered result one cycle after start.
- Iterative ops (mul, divu, remu) take WIDTH cycles.
- Sits between operand-select muxes and writeback. A start/done handshake lets the control FSM stall on long ops.

---
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mc.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Operand/result bundle between the control FSM and the multi-cycle ALU.
// The controller drives start/op/a/b; the ALU answers with busy/done/result/zero.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic             start;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle ops answer one cycle after start,
// mul/divu/remu iterate one bit per cycle for WIDTH cycles. Result and zero
// are registered and held until the next done pulse.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int OPW   = 5
) (
  input  logic     clk,
  input  logic     rstn,
  alu_mc_if.slave  bus
);

  localparam logic [OPW-1:0] OP_LUI   = OPW'(5'd1);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(5'd2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(5'd3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(5'd4);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5'd5);
  localparam logic [OPW-1:0] OP_OR    = OPW'(5'd6);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5'd7);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(5'd8);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(5'd9);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(5'd10);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(5'd11);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(5'd12);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(5'd13);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(5'd14);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(5'd15);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Iteration registers are shared between MUL and DIV:
  //   MUL: r_opa = shifted multiplicand, r_opb = multiplier (shifts right), r_acc = partial product
  //   DIV: r_opa = divisor,              r_opb = dividend -> quotient,     r_acc = partial remainder
  logic [WIDTH-1:0] r_opa, w_opa_nxt;
  logic [WIDTH-1:0] r_opb, w_opb_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [SHW-1:0]   r_cnt, w_cnt_nxt;
  logic             r_is_rem, w_is_rem_nxt;

  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_wr;
  logic [SHW-1:0]   w_shamt;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_div_res;

  assign w_shamt = bus.b[SHW-1:0];

  // Single-cycle operation results; w_alu_wr low means result/zero keep their value.
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    w_alu_wr  = 1'b1;
    case (bus.op)
      OP_LUI, OP_AUIPC, OP_ADD: w_alu_res = bus.a + bus.b;
      OP_SUB:  w_alu_res = bus.a - bus.b;
      OP_AND:  w_alu_res = bus.a & bus.b;
      OP_OR:   w_alu_res = bus.a | bus.b;
      OP_XOR:  w_alu_res = bus.a ^ bus.b;
      OP_SLL:  w_alu_res = bus.a << w_shamt;
      OP_SRL:  w_alu_res = bus.a >> w_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(bus.a) >>> w_shamt);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: w_alu_wr  = 1'b0;
    endcase
  end

  // One shift-add step and one restoring-division step on the current registers.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  always_comb begin
    w_mul_acc  = r_acc + (r_opb[0] ? r_opa : {WIDTH{1'b0}});
    w_rem_sh   = {r_acc, r_opb[WIDTH-1]};
    w_rem_ge   = (w_rem_sh >= {1'b0, r_opa});
    w_rem_diff = w_rem_sh - {1'b0, r_opa};
    if (w_rem_ge) begin
      w_rem_nxt = w_rem_diff[WIDTH-1:0];
    end else begin
      w_rem_nxt = w_rem_sh[WIDTH-1:0];
    end
    w_quo_nxt  = {r_opb[WIDTH-2:0], w_rem_ge};
    if (r_is_rem) begin
      w_div_res = w_rem_nxt;
    end else begin
      w_div_res = w_quo_nxt;
    end
  end

  // Next-state and next-register logic for the IDLE/MUL/DIV controller.
  always_comb begin
    w_state_nxt  = r_state;
    w_opa_nxt    = r_opa;
    w_opb_nxt    = r_opb;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_is_rem_nxt = r_is_rem;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MUL: begin
              w_state_nxt = ST_MUL;
              w_opa_nxt   = bus.a;
              w_opb_nxt   = bus.b;
              w_acc_nxt   = {WIDTH{1'b0}};
              w_cnt_nxt   = {SHW{1'b0}};
              w_busy_nxt  = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
              w_state_nxt  = ST_DIV;
              w_opa_nxt    = bus.b;
              w_opb_nxt    = bus.a;
              w_acc_nxt    = {WIDTH{1'b0}};
              w_cnt_nxt    = {SHW{1'b0}};
              w_is_rem_nxt = (bus.op == OP_REMU);
              w_busy_nxt   = 1'b1;
            end
            default: begin
              w_done_nxt = 1'b1;
              if (w_alu_wr) begin
                w_result_nxt = w_alu_res;
                w_zero_nxt   = (w_alu_res == {WIDTH{1'b0}});
              end else begin
                w_result_nxt = r_result;
                w_zero_nxt   = r_zero;
              end
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_acc_nxt = w_mul_acc;
        w_opa_nxt = r_opa << 1;
        w_opb_nxt = r_opb >> 1;
        w_cnt_nxt = r_cnt + {{(SHW-1){1'b0}}, 1'b1};
        if (r_cnt == CNT_LAST) begin
          w_state_nxt  = ST_IDLE;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_mul_acc;
          w_zero_nxt   = (w_mul_acc == {WIDTH{1'b0}});
          w_cnt_nxt    = {SHW{1'b0}};
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_DIV: begin
        w_acc_nxt = w_rem_nxt;
        w_opb_nxt = w_quo_nxt;
        w_cnt_nxt = r_cnt + {{(SHW-1){1'b0}}, 1'b1};
        if (r_cnt == CNT_LAST) begin
          w_state_nxt  = ST_IDLE;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_div_res;
          w_zero_nxt   = (w_div_res == {WIDTH{1'b0}});
          w_cnt_nxt    = {SHW{1'b0}};
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = {SHW{1'b0}};
      end
    endcase
  end

  // Controller state register; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_opa    <= {WIDTH{1'b0}};
      r_opb    <= {WIDTH{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_cnt    <= {SHW{1'b0}};
      r_is_rem <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_opa    <= w_opa_nxt;
      r_opb    <= w_opb_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_is_rem <= w_is_rem_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8. The driver pushes the
// expected result/zero/done-cycle for each accepted op; per-instance monitors
// pop and compare on every done pulse.
module tb_alu_mc;

  logic clk;
  logic rstn;
  int   cyc;

  alu_mc_if #(.WIDTH(32), .OPW(5)) if32 ();
  alu_mc_if #(.WIDTH(8),  .OPW(5)) if8 ();

  alu_mc #(.WIDTH(32)) u_dut32 (.clk(clk), .rstn(rstn), .bus(if32));
  alu_mc #(.WIDTH(8))  u_dut8  (.clk(clk), .rstn(rstn), .bus(if8));

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32;
  exp_t        e8;
  logic [31:0] last32;
  logic [31:0] last8;
  int          n_vec;
  int          n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference behaviour from the opcode table, plain integer arithmetic mod 2^w.
  function automatic logic [31:0] model(input int w, input logic [4:0] op,
                                        input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] prev);
    longint m, a, b, sa, sb, r;
    int     sh;
    m  = (64'sd1 <<< w) - 64'sd1;
    a  = longint'(a_i) & m;
    b  = longint'(b_i) & m;
    sh = int'(b % longint'(w));
    sa = a[w-1] ? a - (64'sd1 <<< w) : a;
    sb = b[w-1] ? b - (64'sd1 <<< w) : b;
    case (op)
      5'd1, 5'd2, 5'd3: r = a + b;
      5'd4:  r = a - b;
      5'd5:  r = a & b;
      5'd6:  r = a | b;
      5'd7:  r = a ^ b;
      5'd8:  r = a << sh;
      5'd9:  r = a >> sh;
      5'd10: r = sa >>> sh;
      5'd11: r = (sa < sb) ? 64'sd1 : 64'sd0;
      5'd12: r = (a < b) ? 64'sd1 : 64'sd0;
      5'd13: r = a * b;
      5'd14: r = (b == 64'sd0) ? m : a / b;
      5'd15: r = (b == 64'sd0) ? a : a % b;
      default: r = longint'(prev);
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  function automatic logic bsy(input int w);
    return (w == 32) ? if32.busy : if8.busy;
  endfunction

  // Drive one op at the current falling edge, record its expectation, release start a cycle later.
  task automatic issue(input int w, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    lat = (op >= 5'd13 && op <= 5'd15) ? w : 0;
    if (w == 32) begin
      e.res  = model(32, op, a, b, last32);
      last32 = e.res;
      e.z    = (e.res == 32'd0);
      e.cyc  = cyc + 1 + lat;
      q32.push_back(e);
      if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b;
    end else begin
      e.res  = model(8, op, a, b, last8);
      last8  = e.res;
      e.z    = (e.res == 32'd0);
      e.cyc  = cyc + 1 + lat;
      q8.push_back(e);
      if8.start = 1'b1; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end
    @(negedge clk);
    if (w == 32) if32.start = 1'b0;
    else         if8.start = 1'b0;
  endtask

  // Wait (bounded) for an iterative op to finish.
  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (bsy(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  // WIDTH=32 monitor.
  always @(negedge clk) begin
    if (if32.done === 1'b1) begin
      if (q32.size() == 0) begin
        chk("done32_unexpected", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        chk("result32", 64'(if32.result), 64'(e32.res));
        chk("zero32", 64'(if32.zero), 64'(e32.z));
        chk("done32_cycle", 64'(cyc), 64'(e32.cyc));
      end
    end
  end

  // WIDTH=8 monitor.
  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        chk("result8", 64'(if8.result), 64'(e8.res[7:0]));
        chk("zero8", 64'(if8.zero), 64'(e8.z));
        chk("done8_cycle", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int          nb;
    n_vec = 0; n_err = 0; cyc = 0;
    last32 = 32'd0; last8 = 32'd0;
    rstn = 1'b0;
    if32.start = 1'b0; if32.op = 5'd0; if32.a = 32'd0; if32.b = 32'd0;
    if8.start = 1'b0;  if8.op = 5'd0;  if8.a = 8'd0;   if8.b = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(if32.result), 64'd0);
    chk("rst_zero", 64'(if32.zero), 64'd1);
    chk("rst_done", 64'(if32.done), 64'd0);
    chk("rst_busy", 64'(if32.busy), 64'd0);
    chk("rst_result8", 64'(if8.result), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // add then back-to-back sub giving zero
    issue(32, 5'd3, 32'd5, 32'd7);
    issue(32, 5'd4, 32'd3, 32'd3);
    // shifts and compares
    issue(32, 5'd10, 32'h8000_0000, 32'h21);
    issue(32, 5'd9,  32'h8000_0000, 32'h21);
    issue(32, 5'd11, 32'hFFFF_FFFF, 32'd1);
    issue(32, 5'd12, 32'hFFFF_FFFF, 32'd1);
    issue(32, 5'd0,  32'd0, 32'd0);
    issue(32, 5'd20, 32'd1, 32'd1);

    // multiply with operand churn and ignored start pulses while busy
    issue(32, 5'd13, 32'h1234_5678, 32'h10);
    nb = 1;
    while (if32.busy && nb < 100) begin
      if32.start = (nb % 3 == 0);
      if32.op    = 5'($urandom_range(0, 31));
      if32.a     = $urandom;
      if32.b     = $urandom;
      @(negedge clk);
      if (if32.busy) nb++;
    end
    if32.start = 1'b0;
    chk("mul_busy_cycles", 64'(nb), 64'd32);

    // division incl. divide by zero
    issue(32, 5'd14, 32'd100, 32'd7); wait_idle(32);
    issue(32, 5'd15, 32'd100, 32'd7); wait_idle(32);
    issue(32, 5'd14, 32'd9, 32'd0);   wait_idle(32);
    issue(32, 5'd15, 32'd9, 32'd0);   wait_idle(32);

    // reset in the middle of a multiply
    issue(32, 5'd13, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (9) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_busy", 64'(if32.busy), 64'd0);
    chk("rstmid_done", 64'(if32.done), 64'd0);
    chk("rstmid_result", 64'(if32.result), 64'd0);
    chk("rstmid_zero", 64'(if32.zero), 64'd1);
    q32.delete(); q8.delete();
    last32 = 32'd0; last8 = 32'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(32, 5'd3, 32'd1, 32'd1);

    // WIDTH=8 directed
    issue(8, 5'd13, 32'h0F, 32'h11); wait_idle(8);
    issue(8, 5'd8,  32'h01, 32'h0F);
    issue(8, 5'd0,  32'h00, 32'h00);
    issue(8, 5'd10, 32'h81, 32'h03);

    // randomized traffic on both widths
    for (int i = 0; i < 120; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      if (i % 2 == 0) begin
        issue(32, rop, ra, rb);
        if (rop >= 5'd13 && rop <= 5'd15) wait_idle(32);
      end else begin
        issue(8, rop, ra, rb);
        if (rop >= 5'd13 && rop <= 5'd15) wait_idle(8);
      end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
